// File: rtl/post_process_pkg.sv
// post_process_pkg: shared state encoding and default widths for the
// post-processing capture/drain buffer.
`timescale 1ns/1ps
package post_process_pkg;

  // Default geometry: 64-bit sample words, 16-bit UART words, 128-deep RAM
  localparam int PP_IN_WIDTH  = 64;
  localparam int PP_OUT_WIDTH = 16;
  localparam int PP_DEPTH     = 128;

  // Session phases: waiting, capturing, serialising out, finished
  typedef enum logic [1:0] {
    PP_IDLE  = 2'd0,
    PP_FILL  = 2'd1,
    PP_DRAIN = 2'd2,
    PP_DONE  = 2'd3
  } pp_state_e;

endpackage

// File: rtl/pp_sdp_ram.sv
// pp_sdp_ram: simple dual-port RAM, one write port and one registered read
// port on a single clock, written so synthesis infers block RAM.
`timescale 1ns/1ps
module pp_sdp_ram #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 128,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the incoming word when enabled
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: one-cycle read latency, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/post_process_buffer.sv
// post_process_buffer: ping-pong capture/drain buffer. Wide acquisition words
// are stored until the RAM is full or acquisition ends, then each stored word
// is sent to the UART as IN_WIDTH/OUT_WIDTH narrow slices.
// Build option: define PP_MSB_FIRST_EN to emit the most-significant slice of
// each word first; otherwise the least-significant slice goes first.
`timescale 1ns/1ps
module post_process_buffer
  import post_process_pkg::*;
#(
  parameter  int IN_WIDTH  = PP_IN_WIDTH,
  parameter  int OUT_WIDTH = PP_OUT_WIDTH,
  parameter  int DEPTH     = PP_DEPTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 begin_pp,
  input  logic                 end_pp,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 write_read,
  output logic                 bram_full,
  output logic                 bram_empty,
  output logic                 ended,
  output logic [AW:0]          level
);

  localparam int            RATIO      = IN_WIDTH / OUT_WIDTH;
  localparam int            SW         = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [SW-1:0] SLICE_LAST = SW'(RATIO - 1);
  localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);

  pp_state_e            state, state_next;
  logic [AW-1:0]        wr_ad, rd_ad;
  logic                 end_seen;
  logic                 rd_req, rd_vld;
  logic [SW-1:0]        slice;
  logic [IN_WIDTH-1:0]  shift_q, shift_next, rd_data;
  logic                 wr_fire, slice_fire, word_done, last_word;

  assign in_ready   = (state == PP_FILL) && !bram_full;
  assign write_read = (state == PP_DRAIN);
  assign ended      = (state == PP_DONE);
  assign wr_fire    = in_valid && in_ready;
  assign slice_fire = out_valid && out_ready;
  assign word_done  = slice_fire && (slice == SLICE_LAST);
  assign last_word  = (level == LEVEL_ONE);
  assign out_last   = out_valid && end_seen && last_word && (slice == SLICE_LAST);

`ifdef PP_MSB_FIRST_EN
  assign out_data   = shift_q[IN_WIDTH-1 -: OUT_WIDTH];
  assign shift_next = shift_q << OUT_WIDTH;
`else
  assign out_data   = shift_q[OUT_WIDTH-1:0];
  assign shift_next = shift_q >> OUT_WIDTH;
`endif

  pp_sdp_ram #(
    .WIDTH (IN_WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire && begin_pp),
    .wr_addr (wr_ad),
    .wr_data (in_data),
    .rd_en   (rd_req),
    .rd_addr (rd_ad),
    .rd_data (rd_data)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= PP_IDLE;
    else          state <= state_next;
  end

  // Next-state decode; dropping begin_pp abandons the session from any state
  always_comb begin
    state_next = state;
    if (!begin_pp) begin
      state_next = PP_IDLE;
    end else begin
      case (state)
        PP_IDLE:  state_next = PP_FILL;
        PP_FILL: begin
          if (bram_full || (end_seen && (level != '0))) state_next = PP_DRAIN;
          else if (end_seen)                           state_next = PP_DONE;
        end
        PP_DRAIN: begin
          if (word_done && last_word) state_next = end_seen ? PP_DONE : PP_FILL;
        end
        PP_DONE:  state_next = PP_DONE;
        default:  state_next = PP_IDLE;
      endcase
    end
  end

  // Fill counters, read pipeline and slice serialiser
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ad      <= '0;
      rd_ad      <= '0;
      level      <= '0;
      bram_full  <= 1'b0;
      bram_empty <= 1'b0;
      end_seen   <= 1'b0;
      rd_req     <= 1'b0;
      rd_vld     <= 1'b0;
      out_valid  <= 1'b0;
      slice      <= '0;
      shift_q    <= '0;
    end else if (!begin_pp) begin
      wr_ad      <= '0;
      rd_ad      <= '0;
      level      <= '0;
      bram_full  <= 1'b0;
      bram_empty <= 1'b0;
      end_seen   <= 1'b0;
      rd_req     <= 1'b0;
      rd_vld     <= 1'b0;
      out_valid  <= 1'b0;
      slice      <= '0;
      shift_q    <= '0;
    end else begin
      bram_empty <= 1'b0;
      rd_req     <= 1'b0;
      rd_vld     <= rd_req;
      case (state)
        PP_FILL: begin
          if (end_pp) end_seen <= 1'b1;
          if (wr_fire) begin
            wr_ad <= wr_ad + AW'(1);
            level <= level + LEVEL_ONE;
            if (level == (LEVEL_FULL - LEVEL_ONE)) bram_full <= 1'b1;
          end
          if (state_next == PP_DRAIN) rd_req <= 1'b1;
        end
        PP_DRAIN: begin
          if (rd_vld) begin
            shift_q   <= rd_data;
            out_valid <= 1'b1;
            slice     <= '0;
          end else if (slice_fire) begin
            shift_q <= shift_next;
            if (slice == SLICE_LAST) begin
              out_valid <= 1'b0;
              slice     <= '0;
              level     <= level - LEVEL_ONE;
              if (last_word) begin
                bram_empty <= 1'b1;
                bram_full  <= 1'b0;
                wr_ad      <= '0;
                rd_ad      <= '0;
              end else begin
                rd_ad  <= rd_ad + AW'(1);
                rd_req <= 1'b1;
              end
            end else begin
              slice <= slice + SW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_post_process_buffer.sv
// tb_post_process_buffer: directed scoreboard bench for post_process_buffer
// with a 4-deep RAM. Expected slices are queued as words are written and
// popped as the UART side accepts them. Honours PP_MSB_FIRST_EN when defined.
`timescale 1ns/1ps
module tb_post_process_buffer;

  localparam int IN_W  = 64;
  localparam int OUT_W = 16;
  localparam int DEP   = 4;
  localparam int AW    = 2;
  localparam int RATIO = IN_W / OUT_W;

  logic             clk = 1'b0;
  logic             reset_n, begin_pp, end_pp, in_valid, out_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_ready, out_valid, out_last, write_read;
  logic             bram_full, bram_empty, ended;
  logic [OUT_W-1:0] out_data;
  logic [AW:0]      level;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  post_process_buffer #(
    .IN_WIDTH  (IN_W),
    .OUT_WIDTH (OUT_W),
    .DEPTH     (DEP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .begin_pp   (begin_pp),
    .end_pp     (end_pp),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .write_read (write_read),
    .bram_full  (bram_full),
    .bram_empty (bram_empty),
    .ended      (ended),
    .level      (level)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [OUT_W-1:0] sliceOf(input logic [IN_W-1:0] w, input int k);
`ifdef PP_MSB_FIRST_EN
    return w[IN_W-1-k*OUT_W -: OUT_W];
`else
    return w[k*OUT_W +: OUT_W];
`endif
  endfunction

  task automatic pushWord(input logic [IN_W-1:0] w, input bit final_word);
    for (int k = 0; k < RATIO; k++) begin
      exp_t e;
      e.data = sliceOf(w, k);
      e.last = final_word && (k == RATIO - 1);
      sb_q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the following negedge after the handshake
  task automatic applyStimulus(input logic [IN_W-1:0] w, input bit with_end);
    int waitCycles = 0;
    in_valid = 1'b1;
    in_data  = w;
    end_pp   = with_end;
    while (!in_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("write_accept", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    end_pp   = 1'b0;
  endtask

  // Returns at the negedge preceding the posedge of the n-th handshake
  task automatic drainOutputs(input int n, input bit toggle, input string tag);
    int   got = 0;
    int   cyc = 0;
    exp_t e;
    while (got < n && cyc < 300) begin
      out_ready = toggle ? cyc[0] : 1'b1;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checkOutput({tag, "_extra"}, 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          checkOutput({tag, "_data"}, 64'(out_data), 64'(e.data));
          checkOutput({tag, "_last"}, {63'd0, out_last}, {63'd0, e.last});
          got++;
        end
      end else if (out_valid && sb_q.size() > 0) begin
        checkOutput({tag, "_hold"}, 64'(out_data), 64'(sb_q[0].data));
      end
      if (got < n) begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput({tag, "_count"}, 64'(got), 64'(n));
  endtask

  initial begin
    logic [IN_W-1:0] w;
    bit              ovSeen;

    reset_n   = 1'b0;
    begin_pp  = 1'b0;
    end_pp    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid",  {63'd0, out_valid},  64'd0);
    checkOutput("rst_in_ready",   {63'd0, in_ready},   64'd0);
    checkOutput("rst_write_read", {63'd0, write_read}, 64'd0);
    checkOutput("rst_bram_full",  {63'd0, bram_full},  64'd0);
    checkOutput("rst_bram_empty", {63'd0, bram_empty}, 64'd0);
    checkOutput("rst_ended",      {63'd0, ended},      64'd0);
    checkOutput("rst_level",      64'(level),          64'd0);
    checkOutput("rst_out_data",   64'(out_data),       64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", {63'd0, in_ready}, 64'd0);

    // Basic: single word with end_pp on the same handshake
    begin_pp = 1'b1;
    @(negedge clk);
    checkOutput("fill_in_ready", {63'd0, in_ready}, 64'd1);
    w = 64'h4444_3333_2222_1111;
    pushWord(w, 1'b1);
    applyStimulus(w, 1'b1);
    drainOutputs(RATIO, 1'b0, "basic");
    @(negedge clk);
    checkOutput("basic_ended",     {63'd0, ended},     64'd1);
    checkOutput("basic_out_valid", {63'd0, out_valid}, 64'd0);

    // Full cycle without end
    begin_pp = 1'b0;
    @(negedge clk);
    checkOutput("clear_ended", {63'd0, ended}, 64'd0);
    begin_pp = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEP; i++) begin
      w = {$urandom, $urandom};
      pushWord(w, 1'b0);
      applyStimulus(w, 1'b0);
    end
    checkOutput("full_bram_full", {63'd0, bram_full}, 64'd1);
    checkOutput("full_in_ready",  {63'd0, in_ready},  64'd0);
    checkOutput("full_level",     64'(level),         64'(DEP));
    @(negedge clk);
    checkOutput("full_write_read", {63'd0, write_read}, 64'd1);
    drainOutputs(DEP * RATIO, 1'b0, "full");
    @(negedge clk);
    checkOutput("full_bram_empty", {63'd0, bram_empty}, 64'd1);
    checkOutput("full_level_zero", 64'(level),          64'd0);
    checkOutput("full_back_fill",  {63'd0, write_read}, 64'd0);
    checkOutput("full_refill_rdy", {63'd0, in_ready},   64'd1);
    checkOutput("full_ended",      {63'd0, ended},      64'd0);
    @(negedge clk);
    checkOutput("full_empty_pulse", {63'd0, bram_empty}, 64'd0);

    // Second round, ended by end_pp, drained under backpressure
    w = {$urandom, $urandom};
    pushWord(w, 1'b0);
    applyStimulus(w, 1'b0);
    w = {$urandom, $urandom};
    pushWord(w, 1'b1);
    applyStimulus(w, 1'b1);
    drainOutputs(2 * RATIO, 1'b1, "bp");
    @(negedge clk);
    checkOutput("bp_ended", {63'd0, ended}, 64'd1);

    // end_pp with an empty buffer goes straight to DONE
    begin_pp = 1'b0;
    @(negedge clk);
    begin_pp = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    end_pp    = 1'b1;
    ovSeen    = 1'b0;
    @(negedge clk);
    end_pp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (out_valid) ovSeen = 1'b1;
      if (ended) break;
      @(negedge clk);
    end
    checkOutput("empty_end_ended", {63'd0, ended},  64'd1);
    checkOutput("empty_end_no_out", {63'd0, ovSeen}, 64'd0);

    // Clear mid-fill, next session must restart at address 0
    begin_pp = 1'b0;
    @(negedge clk);
    begin_pp = 1'b1;
    @(negedge clk);
    applyStimulus(64'hAAAA_AAAA_AAAA_0001, 1'b0);
    applyStimulus(64'hBBBB_BBBB_BBBB_0002, 1'b0);
    begin_pp = 1'b0;
    @(negedge clk);
    checkOutput("clr_level",    64'(level),         64'd0);
    checkOutput("clr_in_ready", {63'd0, in_ready},  64'd0);
    begin_pp = 1'b1;
    @(negedge clk);
    w = 64'hCCCC_DDDD_EEEE_FFFF;
    pushWord(w, 1'b1);
    applyStimulus(w, 1'b1);
    drainOutputs(RATIO, 1'b0, "clr");
    @(negedge clk);
    checkOutput("clr_ended", {63'd0, ended}, 64'd1);

    // Asynchronous reset in the middle of a drain
    begin_pp = 1'b0;
    @(negedge clk);
    begin_pp = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEP; i++) begin
      w = {$urandom, $urandom};
      pushWord(w, 1'b0);
      applyStimulus(w, 1'b0);
    end
    drainOutputs(5, 1'b0, "mid");
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst_out_valid",  {63'd0, out_valid},  64'd0);
    checkOutput("arst_write_read", {63'd0, write_read}, 64'd0);
    checkOutput("arst_bram_full",  {63'd0, bram_full},  64'd0);
    checkOutput("arst_level",      64'(level),          64'd0);
    checkOutput("arst_out_data",   64'(out_data),       64'd0);
    checkOutput("arst_out_last",   {63'd0, out_last},   64'd0);
    sb_q.delete();
    @(negedge clk);
    reset_n  = 1'b1;
    begin_pp = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
